// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Optional leading-zero blanking is enabled by defining SEG_DISPLAY_BLANK_EN.
package seg_display_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DONE = 2'd2} state_e;

  localparam int NUM_DIGITS = 4;
  localparam int NUM_REQ    = 2;
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;

  // Index that follows idx in round-robin order.
  function automatic int rr_next(input int idx);
    return (idx + 1) % NUM_REQ;
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler that emits a one-cycle tick every CLK_FREQ/REFRESH_HZ clocks.
module scan_tick_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int REFRESH_HZ = 5000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int DIV = CLK_FREQ / REFRESH_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin owner of the 4-digit display path plus digit-scan sequencer.
// Define SEG_DISPLAY_BLANK_EN to blank digits above the most significant nonzero nibble.
module seg_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int REFRESH_HZ = 5000,
  parameter int HOLD_TICKS = 2000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              main_value,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0][15:0] req_value,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [3:0]               nibble,
  output logic [1:0]               digit_sel,
  output logic [7:0]               an,
  output logic                     dp
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  logic tick;

  scan_tick_gen #(.CLK_FREQ(CLK_FREQ), .REFRESH_HZ(REFRESH_HZ)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  state_e        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   shown_q, shown_d, disp;
  logic [1:0]    digit_q, digit_d;
  logic          lit;

  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               busy_q, busy_d, dp_q, dp_d;
  logic [3:0]         nibble_q, nibble_d;
  logic [1:0]         digit_sel_q, digit_sel_d;
  logic [7:0]         an_q, an_d;

  // Scan from highest offset down so the requester nearest the pointer wins.
  always_comb begin
    pick = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % NUM_REQ]) pick = PW'((int'(ptr_q) + i) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      shown_q <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      shown_q <= shown_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    shown_d = shown_q;
    digit_d = tick ? digit_q + 1'b1 : digit_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = HOLD;
        owner_d = pick;
        shown_d = req_value[pick];
        hold_d  = '0;
      end
      // A dropped request wins over a coincident final tick: abort, no done.
      HOLD: if (!req[owner_q]) begin
        state_d = IDLE;
        ptr_d   = PW'(rr_next(int'(owner_q)));
      end else if (tick) begin
        if (hold_q == HOLD_LAST) state_d = DONE;
        else                     hold_d  = hold_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = PW'(rr_next(int'(owner_q)));
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration outputs lead from next state; scan outputs lag the digit counter.
  always_comb begin
    disp    = (state_q == HOLD) ? shown_q : main_value;
    grant_d = '0;
    done_d  = '0;
    if (state_d == HOLD) grant_d[owner_d] = 1'b1;
    if (state_d == DONE) done_d[owner_d]  = 1'b1;
    busy_d      = (state_d == HOLD);
    nibble_d    = disp[{digit_q, 2'b00} +: 4];
    digit_sel_d = digit_q;
`ifdef SEG_DISPLAY_BLANK_EN
    begin
      logic [1:0] msd;
      msd = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        if (disp[4*i +: 4] != 4'h0) msd = 2'(i);
      end
      lit = (digit_q <= msd);
    end
`else
    lit = 1'b1;
`endif
    an_d = AN_ALL_OFF;
    if (lit) an_d[digit_q] = 1'b0;
    dp_d = !((state_q == HOLD) && (digit_q == 2'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      nibble_q    <= '0;
      digit_sel_q <= '0;
      an_q        <= AN_ALL_OFF;
      dp_q        <= 1'b1;
    end else begin
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      nibble_q    <= nibble_d;
      digit_sel_q <= digit_sel_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign nibble    = nibble_q;
  assign digit_sel = digit_sel_q;
  assign an        = an_q;
  assign dp        = dp_q;
endmodule
